wb_uart: RTL and testbench

- Wishbone B4 classic slave UART; sits downstream of the CPU load/store bus master on the shared data bus.
- Decodes a 16-byte register window. The interconnect decodes the base address and drives CYC_I/STB_I only for this window.
- Transmit path: TX FIFO feeding an 8N1 serialiser.
- Receive path: 8N1 deserialiser feeding a single-byte holding register.
- Provides a level interrupt for polled or IRQ-driven console I/O.

---
 rtl/wb_uart_pkg.sv | 30 +++
 rtl/wb_uart_if.sv | 16 +
 rtl/uart_fifo.sv | 44 ++++
 rtl/wb_uart.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_wb_uart.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_uart_pkg.sv
// Shared constants, FSM state types and divisor helper for the wb_uart block.
package wb_uart_pkg;

  // Register indices selected by ADR_I[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS register bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_VALID  = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_DROP   = 6;

  // Smallest bit period the serialisers will run at
  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Clamp the programmed divisor so a bit never lasts fewer than MIN_DIV clocks
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone B4 classic bus signals between the CPU-side master and the UART slave.
interface wb_uart_if;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;

  modport master (output ADR_I, DAT_I, SEL_I, CYC_I, STB_I, WE_I,
                  input  DAT_O, ACK_O);
  modport slave  (input  ADR_I, DAT_I, SEL_I, CYC_I, STB_I, WE_I,
                  output DAT_O, ACK_O);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout is the head entry whenever !empty.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push to a full FIFO is then accepted
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/wb_uart.sv
// Wishbone classic UART: register decode, TX FIFO + 8N1 serialiser, 8N1 deserialiser.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic      CLK_I,
  input  logic      RST_I,
  wb_uart_if.slave  bus,
  output logic      tx_o,
  input  logic      rx_i,
  output logic      irq_o
);
  // Bus decode
  logic        req, wr, rd, ack_q;
  logic [31:0] dat_q, rdata;
  logic [1:0]  reg_idx;
  logic        data_rd, st_rd;

  // Control/status registers
  logic [15:0] div_q, div_eff;
  logic        ie_rx_q, ie_txe_q;
  logic        rx_valid_q, overrun_q, frame_err_q, tx_drop_q, irq_q;
  logic [7:0]  rx_data_q;
  logic [6:0]  status;

  // FIFO / TX
  logic        tx_push, tx_pop, fifo_full, fifo_empty, tx_drop_evt;
  logic [7:0]  fifo_dout;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;

  // RX
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_land, rx_ferr;

  logic        unused_bits;
  assign unused_bits = ^{bus.ADR_I[31:4], bus.ADR_I[1:0], bus.DAT_I[31:16], bus.SEL_I[3:2]};

  assign req     = bus.CYC_I & bus.STB_I & ~ack_q;
  assign wr      = req & bus.WE_I;
  assign rd      = req & ~bus.WE_I;
  assign reg_idx = bus.ADR_I[3:2];
  assign data_rd = rd & (reg_idx == REG_DATA);
  assign st_rd   = rd & (reg_idx == REG_STATUS);
  assign div_eff = eff_div(div_q);

  assign tx_push     = wr & (reg_idx == REG_DATA) & bus.SEL_I[0];
  assign tx_drop_evt = tx_push & fifo_full & ~tx_pop;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (bus.DAT_I[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Assemble the STATUS view from live state
  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = fifo_full;
    status[ST_TX_EMPTY]  = fifo_empty;
    status[ST_TX_BUSY]   = (tx_state_q != TX_IDLE) | ~fifo_empty;
    status[ST_RX_VALID]  = rx_valid_q;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_DROP]   = tx_drop_q;
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_DATA:   rdata = {24'b0, rx_data_q};
      REG_STATUS: rdata = {25'b0, status};
      REG_DIV:    rdata = {16'b0, div_q};
      REG_CTRL:   rdata = {30'b0, ie_txe_q, ie_rx_q};
      default:    rdata = '0;
    endcase
  end

  // Acknowledge and read data are registered together, one pulse per request
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdata : '0;
    end
  end

  assign bus.ACK_O = ack_q;
  assign bus.DAT_O = dat_q;

  // Register writes, sticky flags and interrupt; set events win over read-clears
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      div_q       <= 16'(DEFAULT_DIV);
      ie_rx_q     <= 1'b0;
      ie_txe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_drop_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr && reg_idx == REG_DIV) begin
        if (bus.SEL_I[0]) div_q[7:0]  <= bus.DAT_I[7:0];
        if (bus.SEL_I[1]) div_q[15:8] <= bus.DAT_I[15:8];
      end
      if (wr && reg_idx == REG_CTRL && bus.SEL_I[0]) begin
        ie_rx_q  <= bus.DAT_I[0];
        ie_txe_q <= bus.DAT_I[1];
      end
      rx_valid_q  <= rx_land | (rx_valid_q & ~data_rd);
      overrun_q   <= (rx_land & rx_valid_q & ~data_rd) | (overrun_q & ~st_rd);
      frame_err_q <= rx_ferr | (frame_err_q & ~st_rd);
      tx_drop_q   <= tx_drop_evt | (tx_drop_q & ~st_rd);
      irq_q       <= (ie_rx_q & rx_valid_q) |
                     (ie_txe_q & fifo_empty & (tx_state_q == TX_IDLE));
    end
  end

  // Received byte holding register
  always_ff @(posedge CLK_I) begin
    if (rx_land) rx_data_q <= rx_shift_q;
  end

  assign irq_o = irq_q;

  // TX next-state: tx_d is the line level for the state being entered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_dout;
          tx_div_d   = div_eff;
          tx_cnt_d   = div_eff - 16'd1;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_dout;
            tx_div_d   = div_eff;
            tx_cnt_d   = div_eff - 16'd1;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state register and line driver
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
    end
    tx_cnt_q   <= tx_cnt_d;
    tx_div_q   <= tx_div_d;
    tx_bit_q   <= tx_bit_d;
    tx_shift_q <= tx_shift_d;
  end

  assign tx_o = tx_q;

  // rx_i synchroniser and previous-sample for falling-edge detect
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // RX next-state: start validated at half a bit, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_land    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_state_d = RX_START;
          rx_div_d   = div_eff;
          rx_cnt_d   = (div_eff >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
            rx_cnt_d   = rx_div_q - 16'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = RX_IDLE;
          rx_land    = rx_s_q;
          rx_ferr    = ~rx_s_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge CLK_I) begin
    if (RST_I) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
    rx_cnt_q   <= rx_cnt_d;
    rx_div_q   <= rx_div_d;
    rx_bit_q   <= rx_bit_d;
    rx_shift_q <= rx_shift_d;
  end
endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: bus handshake, TX serialiser, RX deserialiser, irq.
module tb_wb_uart;
  localparam int FIFO_DEPTH  = 16;
  localparam int DEFAULT_DIV = 434;
  localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_DIV = 2'd2, R_CTRL = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic tx_o, rx_i, irq_o;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // TX line monitor results
  int         cap_start[$];
  logic [9:0] cap_frame[$];

  // RX reference model (holding register semantics)
  logic [7:0] m_data;
  logic       m_have, m_valid, m_ovr, m_ferr;

  wb_uart_if wb_bus ();

  wb_uart #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (wb_bus),
    .tx_o  (tx_o),
    .rx_i  (rx_i),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One classic-cycle transfer; undecoded address bits are randomised
  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                         input logic [3:0] sel, output logic [31:0] rdata);
    logic [27:0] hi;
    logic [1:0]  lo;
    hi = 28'($urandom);
    lo = 2'($urandom);
    wb_bus.ADR_I = {hi, idx, lo};
    wb_bus.DAT_I = wdata;
    wb_bus.SEL_I = sel;
    wb_bus.WE_I  = we;
    wb_bus.CYC_I = 1'b1;
    wb_bus.STB_I = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", wb_bus.ACK_O, 1);
    rdata = wb_bus.DAT_O;
    if (we) chk("wr_dat_o_zero", rdata, 0);
    wb_bus.CYC_I = 1'b0;
    wb_bus.STB_I = 1'b0;
    wb_bus.WE_I  = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", wb_bus.ACK_O, 0);
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    wb_xfer(1'b1, idx, d, sel, r);
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] r);
    wb_xfer(1'b0, idx, 32'h0, 4'hF, r);
  endtask

  task automatic wb_read_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    wb_read(idx, r);
    chk(tag, r, exp);
  endtask

  // Behavioural UART receiver on tx_o: samples each bit cell at its centre
  task automatic capture_tx(input int n, input int div);
    for (int f = 0; f < n; f++) begin
      int w;
      logic [9:0] fr;
      w = 0;
      while (tx_o !== 1'b0 && w < 4000) begin
        @(negedge clk);
        w++;
      end
      if (tx_o !== 1'b0) begin
        chk("tx_frame_timeout", 0, 1);
        return;
      end
      cap_start.push_back(cyc);
      repeat (div / 2) @(negedge clk);
      fr[0] = tx_o;
      for (int b = 1; b < 10; b++) begin
        repeat (div) @(negedge clk);
        fr[b] = tx_o;
      end
      cap_frame.push_back(fr);
    end
  endtask

  // Compare captured frames with the expected byte stream; all back-to-back
  task automatic check_tx(input logic [7:0] exp_q[$], input int div);
    chk("tx_frame_count", cap_frame.size(), exp_q.size());
    for (int i = 0; i < cap_frame.size() && i < exp_q.size(); i++) begin
      chk($sformatf("tx_byte%0d", i), cap_frame[i][8:1], exp_q[i]);
      chk($sformatf("tx_framing%0d", i), {cap_frame[i][9], cap_frame[i][0]}, 2'b10);
      if (i > 0) chk($sformatf("tx_spacing%0d", i), cap_start[i] - cap_start[i-1], 10 * div);
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int div);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = fr[i];
      step(div);
    end
    rx_i = 1'b1;
    step(div);
  endtask

  task automatic m_frame(input logic [7:0] b, input logic ok);
    if (ok) begin
      if (m_valid) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
      m_have  = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // Expected STATUS while the transmitter is idle
  function automatic logic [31:0] m_status();
    return {25'b0, 1'b0, m_ferr, m_ovr, m_valid, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic rd_status(input string tag);
    wb_read_chk(tag, R_STATUS, m_status());
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    wb_read_chk(tag, R_DATA, {24'b0, m_data});
    m_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  exp_q[$];
    logic [9:0]  pat;
    logic [7:0]  b;
    int          d, eff, n, act, accepted;
    logic        m_full, m_drop;

    rst = 1'b1;
    rx_i = 1'b1;
    wb_bus.ADR_I = '0; wb_bus.DAT_I = '0; wb_bus.SEL_I = '0;
    wb_bus.CYC_I = 1'b0; wb_bus.STB_I = 1'b0; wb_bus.WE_I = 1'b0;
    m_data = '0; m_have = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    step(3);
    chk("rst_tx", tx_o, 1);
    chk("rst_ack", wb_bus.ACK_O, 0);
    chk("rst_dat", wb_bus.DAT_O, 0);
    chk("rst_irq", irq_o, 0);
    rst = 1'b0;
    step(1);

    wb_read_chk("rst_status", R_STATUS, 32'h02);
    wb_read_chk("rst_div", R_DIV, DEFAULT_DIV);
    wb_read_chk("rst_ctrl", R_CTRL, 32'h0);

    // Byte lanes on DIVISOR, and a DATA write without lane 0 pushes nothing
    wb_write(R_DIV, 32'hFFFF1234, 4'hF);
    wb_write(R_DIV, 32'h0000ABCD, 4'b0010);
    wb_read_chk("div_lanes", R_DIV, 32'hAB34);
    wb_write(R_DATA, 32'h000000AA, 4'b1110);
    wb_read_chk("data_nolane", R_STATUS, 32'h02);

    // Single frame 0x55 at 4 clocks per bit
    wb_write(R_DIV, 32'd4, 4'hF);
    cap_start.delete(); cap_frame.delete();
    fork
      capture_tx(1, 4);
      begin
        wb_write(R_DATA, 32'h55, 4'hF);
        step(6);
        wb_read(R_STATUS, r);
        chk("busy_mid_frame", r[2], 1);
      end
    join
    step(1);
    pat = {1'b1, 8'h55, 1'b0};
    if (cap_frame.size() == 1)
      for (int i = 0; i < 10; i++) chk($sformatf("tx55_bit%0d", i), cap_frame[0][i], pat[i]);
    else
      chk("tx55_count", cap_frame.size(), 1);
    step(6);
    wb_read_chk("idle_after_55", R_STATUS, 32'h02);

    // 17 bytes pushed quickly: one in the shifter, 16 in the FIFO, none dropped
    exp_q.delete();
    for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
    cap_start.delete(); cap_frame.delete();
    fork
      capture_tx(17, 4);
      for (int i = 0; i <= 16; i++) wb_write(R_DATA, 32'(i), 4'hF);
    join
    step(8);
    check_tx(exp_q, 4);
    wb_read_chk("b2b_status", R_STATUS, 32'h02);

    // Random divisors (including values below the clamp) and random bytes
    for (int k = 0; k < 2; k++) begin
      d   = $urandom_range(0, 12);
      eff = (d < 4) ? 4 : d;
      n   = $urandom_range(1, 6);
      wb_write(R_DIV, 32'(d), 4'hF);
      wb_read_chk("div_rand", R_DIV, 32'(d));
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      cap_start.delete(); cap_frame.delete();
      fork
        capture_tx(n, eff);
        for (int i = 0; i < n; i++) wb_write(R_DATA, {24'b0, exp_q[i]}, 4'hF);
      join
      step(2 * eff);
      check_tx(exp_q, eff);
    end

    // Stalled transmitter: capacity is the FIFO plus the shifter
    wb_write(R_DIV, 32'hFFFF, 4'hF);
    for (int i = 0; i < 18; i++) wb_write(R_DATA, 32'(i), 4'hF);
    accepted = (18 < FIFO_DEPTH + 1) ? 18 : FIFO_DEPTH + 1;
    m_full = (accepted - 1) == FIFO_DEPTH;
    m_drop = (18 > accepted);
    wb_read_chk("drop_status", R_STATUS, {25'b0, m_drop, 3'b000, 1'b1, 1'b0, m_full});
    wb_read_chk("drop_cleared", R_STATUS, {25'b0, 1'b0, 3'b000, 1'b1, 1'b0, m_full});
    chk("tx_low_in_start", tx_o, 0);
    rst = 1'b1;
    step(1);
    chk("tx_high_after_rst", tx_o, 1);
    step(1);
    rst = 1'b0;
    step(1);
    wb_read_chk("status_after_rst", R_STATUS, 32'h02);
    wb_read_chk("div_after_rst", R_DIV, DEFAULT_DIV);

    // Receive path at 8 clocks per bit
    wb_write(R_DIV, 32'd8, 4'hF);
    drive_rx(8'hA3, 1'b1, 8); m_frame(8'hA3, 1'b1);
    rd_status("rx_valid_set");
    rd_data("rx_a3");
    rd_status("rx_valid_clr");
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      drive_rx(b, 1'b1, 8); m_frame(b, 1'b1);
    end
    rd_status("overrun_set");
    rd_status("overrun_clr");
    rd_data("overrun_newest");
    b = 8'($urandom);
    drive_rx(b, 1'b1, 8); m_frame(b, 1'b1);
    b = 8'($urandom);
    drive_rx(b, 1'b0, 8); m_frame(b, 1'b0);
    rd_status("frame_err");
    rd_data("frame_err_keeps_old");
    rx_i = 1'b0;
    step(2);
    rx_i = 1'b1;
    step(20);
    rd_status("glitch_ignored");

    // Randomised mix of good frames, bad frames and register reads
    for (int i = 0; i < 10; i++) begin
      act = $urandom_range(0, 4);
      b   = 8'($urandom);
      case (act)
        0, 1: begin drive_rx(b, 1'b1, 8); m_frame(b, 1'b1); end
        2:    begin drive_rx(b, 1'b0, 8); m_frame(b, 1'b0); end
        3:    rd_status("rand_status");
        default: if (m_have) rd_data("rand_data"); else rd_status("rand_status");
      endcase
    end
    rd_status("rand_final_status");

    // Interrupts
    b = 8'($urandom);
    drive_rx(b, 1'b1, 8); m_frame(b, 1'b1);
    rd_data("irq_pre_drain");
    wb_write(R_CTRL, 32'h1, 4'hF);
    wb_read_chk("ctrl_rx", R_CTRL, 32'h1);
    chk("irq_idle", irq_o, 0);
    b = 8'($urandom);
    drive_rx(b, 1'b1, 8); m_frame(b, 1'b1);
    chk("irq_rx_set", irq_o, 1);
    step(5);
    chk("irq_rx_held", irq_o, 1);
    rd_data("irq_data");
    chk("irq_rx_clr", irq_o, 0);
    wb_write(R_CTRL, 32'hFFFFFFFF, 4'hF);
    wb_read_chk("ctrl_mask", R_CTRL, 32'h3);
    step(1);
    chk("irq_tx_empty", irq_o, 1);
    wb_write(R_CTRL, 32'h0, 4'hF);
    step(2);
    chk("irq_off", irq_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
